ps2_kb_decoder: RTL and testbench
=================================

PS2_KB_DECODER -- requirements
Module: ps2_kb_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, giving the cycles ps2_clk must be stable before an edge is accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65000, giving the idle clk cycles mid-frame before the frame is aborted.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; the block uses one clock only.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: raw keyboard clock, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: raw keyboard data, asynchronous to clk.
REQ-007 The block SHALL have port key_code, output, 8 bits: last decoded scan code, held until the next event.
REQ-008 The block SHALL have port key_pressed, output, 1 bit: 1 = make, 0 = break for key_code, held.
REQ-009 The block SHALL have port key_extended, output, 1 bit: 1 when key_code was E0-prefixed, held.
REQ-010 The block SHALL have port key_valid, output, 1 bit: one-cycle strobe marking a new key event.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass a 2-flop synchroniser before use.
REQ-012 A ps2_clk falling edge SHALL be accepted only after ps2_clk has been stable high for FILTER_LEN cycles and then stable low for FILTER_LEN cycles.
REQ-013 The receiver SHALL sample ps2_data on each accepted falling edge, forming an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-014 The receiver FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on an accepted edge with data 0.
- SHIFT -> DONE after the 11th bit.
- DONE -> IDLE after 1 cycle.
REQ-015 A frame with start != 0 or stop != 1 SHALL be discarded silently.
REQ-016 If no accepted edge arrives for TIMEOUT_CYCLES while in SHIFT, the bit counter SHALL clear, the state SHALL return to IDLE and the partial frame SHALL be dropped.
REQ-017 The byte-valid strobe from DONE SHALL feed the decoder FSM with states NORMAL, BRK, EXT and EXT_BRK.
REQ-018 In NORMAL, byte F0 SHALL go to BRK, byte E0 SHALL go to EXT, and any other byte SHALL emit a make event.
REQ-019 In BRK, any byte other than E0/F0 SHALL emit a break event and return to NORMAL.
REQ-020 In EXT, F0 SHALL go to EXT_BRK; any other byte SHALL emit an extended make and return to NORMAL.
REQ-021 In EXT_BRK, any byte SHALL emit an extended break and return to NORMAL.
REQ-022 In BRK, byte E0 or F0 SHALL be treated as protocol noise and return to NORMAL with no event.
REQ-023 Bytes AA, FA, EE and FE received in NORMAL SHALL be ignored, producing no event.
REQ-024 On an event, key_code, key_pressed and key_extended SHALL update, and key_valid SHALL pulse, in the cycle after the receiver DONE cycle (1-cycle decode latency).
REQ-025 Make and break of the same key SHALL set key_pressed 1 and then 0, with key_code identical for both events.
REQ-026 Auto-repeat makes SHALL each produce a fresh key_valid pulse.

Reset
REQ-027 Reset SHALL force key_code=00, key_pressed=0, key_extended=0, key_valid=0, both FSMs to IDLE/NORMAL, and clear the counters and synchronisers to idle-high.
REQ-028 Reset asserted mid-frame SHALL abort that frame; after release, decoding SHALL resume from the next start bit.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, frames with even parity SHALL be discarded and SHALL NOT advance the decoder FSM.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored, and the port list and latency SHALL be unchanged.

Structure
REQ-031 The shared package SHALL hold the constants for the codes F0, E0, AA, FA, EE and FE, plus the decoder-state and receiver-state encodings.
REQ-032 The frame receiver (synchroniser, filter, shift register, timeout) SHALL be the sub-module ps2_rx, outputting rx_data[7:0] and rx_done.
REQ-033 The decoder FSM and output registers SHALL reside in ps2_kb_decoder.

Verification
REQ-034 Frame 1D (make W) -> key_code=1D, key_pressed=1, key_extended=0, with one key_valid pulse.
REQ-035 Frames F0,1D -> key_code=1D, key_pressed=0, and exactly one key_valid pulse (on 1D).
REQ-036 Frames E0,75 then E0,F0,75 -> two events: key_code=75, key_extended=1, key_pressed 1 then 0.
REQ-037 Frame 5A with 3 ps2_clk glitches of 2 clk cycles each -> glitches ignored, single event key_code=5A.
REQ-038 Stop after 6 bits, idle for TIMEOUT_CYCLES, then frame 12 -> only event is key_code=12, key_pressed=1.
REQ-039 With PS2_PARITY_CHECK_EN, frame 1B with bad parity -> no key_valid; without the macro -> key_code=1B, key_pressed=1.

Source files
------------

// File: rtl/ps2_kb_decoder_pkg.sv
// Shared scan-code constants and FSM encodings for the PS/2 keyboard decoder.
package ps2_kb_decoder_pkg;

  localparam logic [7:0] KB_BRK    = 8'hF0;
  localparam logic [7:0] KB_EXT    = 8'hE0;
  localparam logic [7:0] KB_BAT    = 8'hAA;
  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_ECHO   = 8'hEE;
  localparam logic [7:0] KB_RESEND = 8'hFE;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DONE
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  // Keyboard status/handshake bytes that never denote a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == KB_BAT) || (b == KB_ACK) || (b == KB_ECHO) || (b == KB_RESEND);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchroniser, ps2_clk glitch filter, shift register, timeout.
// Define PS2_PARITY_CHECK_EN to drop frames whose odd-parity bit is wrong.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_done
);
  import ps2_kb_decoder_pkg::*;

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    cs_q, ds_q;
  logic          clk_s, data_s;
  logic          lvl_q, hi_ok_q;
  logic [CW-1:0] cnt_q;
  logic          stable, fall;

  rx_state_t     st_q;
  logic [3:0]    bit_q;
  logic [7:0]    sr_q, rx_data_q;
  logic [TW-1:0] to_q;
  logic          rx_done_q;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q <= 2'b11;
      ds_q <= 2'b11;
    end else begin
      cs_q <= {cs_q[0], ps2_clk};
      ds_q <= {ds_q[0], ps2_data};
    end
  end

  assign clk_s  = cs_q[1];
  assign data_s = ds_q[1];

  // cnt_q = cycles lvl_q has held its value; an edge needs a settled high then a settled low.
  assign stable = (cnt_q == CW'(FILTER_LEN));
  assign fall   = stable & ~lvl_q & hi_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      hi_ok_q <= 1'b0;
    end else begin
      lvl_q <= clk_s;
      if (clk_s != lvl_q)  cnt_q <= CW'(1);
      else if (!stable)    cnt_q <= cnt_q + CW'(1);
      if (stable && lvl_q) hi_ok_q <= 1'b1;
      else if (fall)       hi_ok_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= RX_IDLE;
      bit_q     <= '0;
      sr_q      <= '0;
      to_q      <= '0;
      rx_data_q <= '0;
      rx_done_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rx_done_q <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          if (fall && !data_s) begin
            st_q  <= RX_SHIFT;
            bit_q <= 4'd1;
            to_q  <= '0;
          end
        end
        RX_SHIFT: begin
          if (fall) begin
            to_q  <= '0;
            bit_q <= bit_q + 4'd1;
            if (bit_q <= 4'd8) sr_q <= {data_s, sr_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
            else if (bit_q == 4'd9) par_q <= data_s;
`endif
            if (bit_q == 4'd10) begin
              st_q      <= RX_DONE;
              bit_q     <= '0;
              rx_data_q <= sr_q;
`ifdef PS2_PARITY_CHECK_EN
              rx_done_q <= data_s & (^{sr_q, par_q});
`else
              rx_done_q <= data_s;
`endif
            end
          end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            st_q  <= RX_IDLE;
            bit_q <= '0;
            to_q  <= '0;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        RX_DONE: st_q <= RX_IDLE;
        default: st_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard scan-code decoder: make/break/extended events from ps2_rx bytes.
// PS2_PARITY_CHECK_EN (see ps2_rx) enables parity-based frame rejection.
module ps2_kb_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       key_valid
);
  import ps2_kb_decoder_pkg::*;

  logic [7:0] rx_data;
  logic       rx_done;

  dec_state_t dst_q;
  logic [7:0] key_code_q;
  logic       key_pressed_q, key_extended_q, key_valid_q;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_q          <= DEC_NORMAL;
      key_code_q     <= '0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      key_valid_q    <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (rx_done) begin
        case (dst_q)
          DEC_NORMAL: begin
            if (rx_data == KB_BRK)      dst_q <= DEC_BRK;
            else if (rx_data == KB_EXT) dst_q <= DEC_EXT;
            else if (!is_ignored(rx_data)) begin
              key_code_q     <= rx_data;
              key_pressed_q  <= 1'b1;
              key_extended_q <= 1'b0;
              key_valid_q    <= 1'b1;
            end
          end
          DEC_BRK: begin
            dst_q <= DEC_NORMAL;
            // A prefix right after F0 is a broken sequence; resync silently.
            if (rx_data != KB_BRK && rx_data != KB_EXT) begin
              key_code_q     <= rx_data;
              key_pressed_q  <= 1'b0;
              key_extended_q <= 1'b0;
              key_valid_q    <= 1'b1;
            end
          end
          DEC_EXT: begin
            if (rx_data == KB_BRK) dst_q <= DEC_EXT_BRK;
            else begin
              dst_q          <= DEC_NORMAL;
              key_code_q     <= rx_data;
              key_pressed_q  <= 1'b1;
              key_extended_q <= 1'b1;
              key_valid_q    <= 1'b1;
            end
          end
          DEC_EXT_BRK: begin
            dst_q          <= DEC_NORMAL;
            key_code_q     <= rx_data;
            key_pressed_q  <= 1'b0;
            key_extended_q <= 1'b1;
            key_valid_q    <= 1'b1;
          end
          default: dst_q <= DEC_NORMAL;
        endcase
      end
    end
  end

  assign key_code     = key_code_q;
  assign key_pressed  = key_pressed_q;
  assign key_extended = key_extended_q;
  assign key_valid    = key_valid_q;

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Bench for ps2_kb_decoder: keyboard-side frame generator, event-queue model, per-cycle compare.
module tb_ps2_kb_decoder;
  localparam int FLT = 8;
  localparam int TMO = 2000;
  localparam int HP  = 20;

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_pressed, key_extended, key_valid;

  typedef struct {
    logic [7:0] code;
    logic       pr;
    logic       ex;
  } ev_t;

  ev_t expq[$];
  ev_t last;
  int  checks = 0, errors = 0, pulses = 0;
  bit  m_brk = 0, m_ext = 0;

  ps2_kb_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic void push_ev(input logic [7:0] c, input logic pr, input logic ex);
    ev_t e;
    e.code = c; e.pr = pr; e.ex = ex;
    expq.push_back(e);
  endfunction

  // Keyboard protocol: F0 = release prefix, E0 = extended prefix, status bytes carry no key.
  function automatic void model_byte(input logic [7:0] b);
    bit is_pfx, ign;
    is_pfx = (b == 8'hF0) || (b == 8'hE0);
    ign    = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE);
    if (m_ext && m_brk) begin
      push_ev(b, 1'b0, 1'b1); m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else begin push_ev(b, 1'b1, 1'b1); m_ext = 0; end
    end else if (m_brk) begin
      if (!is_pfx) push_ev(b, 1'b0, 1'b0);
      m_brk = 0;
    end else begin
      if (b == 8'hF0)      m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (!ign)       push_ev(b, 1'b1, 1'b0);
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                            input bit bad_stop, input int nglitch);
    logic [10:0] f;
    bit ok;
    f  = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    ok = (nbits == 11) && !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && !bad_par;
`endif
    if (ok) model_byte(b);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i < nglitch) begin
        cyc(12); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(HP - 14);
      end else cyc(HP);
      ps2_clk = 1'b0;
      cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(2 * HP);
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() != 0 && k < 200) begin cyc(1); k++; end
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] c, input logic pr,
                            input logic ex, input int dpul, input int p0);
    check({nm, "_code"}, key_code, c);
    check({nm, "_pressed"}, key_pressed, pr);
    check({nm, "_ext"}, key_extended, ex);
    check({nm, "_pulses"}, pulses - p0, dpul);
  endtask

  // Every cycle: a strobe must match the next queued event; otherwise outputs hold.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last.code = 8'h00; last.pr = 1'b0; last.ex = 1'b0;
        check("reset_outputs", {key_code, key_pressed, key_extended, key_valid}, 11'h0);
      end else if (key_valid) begin
        pulses++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got code %0h pr %0b ex %0b expected no event",
                   key_code, key_pressed, key_extended);
        end else begin
          e = expq.pop_front();
          check("ev_code", key_code, e.code);
          check("ev_pressed", key_pressed, e.pr);
          check("ev_ext", key_extended, e.ex);
          last = e;
        end
      end else begin
        check("hold", {key_code, key_pressed, key_extended}, {last.code, last.pr, last.ex});
      end
    end
  end

  initial begin
    int p0;
    cyc(10);
    reset = 1'b0;
    cyc(20);
    expect_out("post_reset", 8'h00, 1'b0, 1'b0, 0, pulses);

    p0 = pulses; send_frame(8'h1D, 11, 0, 0, 0); drain();
    expect_out("make_w", 8'h1D, 1'b1, 1'b0, 1, p0);

    p0 = pulses; send_frame(8'hF0, 11, 0, 0, 0); send_frame(8'h1D, 11, 0, 0, 0); drain();
    expect_out("break_w", 8'h1D, 1'b0, 1'b0, 1, p0);

    p0 = pulses; send_frame(8'hE0, 11, 0, 0, 0); send_frame(8'h75, 11, 0, 0, 0); drain();
    expect_out("ext_make", 8'h75, 1'b1, 1'b1, 1, p0);
    send_frame(8'hE0, 11, 0, 0, 0); send_frame(8'hF0, 11, 0, 0, 0);
    send_frame(8'h75, 11, 0, 0, 0); drain();
    expect_out("ext_break", 8'h75, 1'b0, 1'b1, 2, p0);

    p0 = pulses; send_frame(8'h5A, 11, 0, 0, 3); drain();
    expect_out("glitch", 8'h5A, 1'b1, 1'b0, 1, p0);

    p0 = pulses; send_frame(8'h77, 6, 0, 0, 0); cyc(TMO + 50);
    send_frame(8'h12, 11, 0, 0, 0); drain();
    expect_out("timeout", 8'h12, 1'b1, 1'b0, 1, p0);

    p0 = pulses; send_frame(8'h1B, 11, 1, 0, 0); drain();
`ifdef PS2_PARITY_CHECK_EN
    expect_out("bad_parity", 8'h12, 1'b1, 1'b0, 0, p0);
`else
    expect_out("bad_parity", 8'h1B, 1'b1, 1'b0, 1, p0);
`endif

    p0 = pulses; send_frame(8'h44, 11, 0, 1, 0); send_frame(8'hAA, 11, 0, 0, 0); drain();
    check("no_event_pulses", pulses - p0, 0);

    p0 = pulses;
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 11, 0, 0, 0);
    drain();
    expect_out("repeat", 8'h1C, 1'b1, 1'b0, 3, p0);

    // Reset with ps2_clk low in the middle of a frame, then a clean frame.
    for (int i = 0; i < 4; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      cyc(HP); ps2_clk = 1'b0; cyc(HP);
      if (i != 3) ps2_clk = 1'b1;
    end
    reset = 1'b1; cyc(5);
    m_brk = 0; m_ext = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    cyc(2); reset = 1'b0; cyc(2 * HP);
    p0 = pulses; send_frame(8'h1D, 11, 0, 0, 0); drain();
    expect_out("after_reset", 8'h1D, 1'b1, 1'b0, 1, p0);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = 8'hAA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, 11, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 2));
      drain();
    end

    cyc(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
